fc2_collector: RTL and testbench
================================

FC2_COLLECTOR -- requirements
Module: fc2_collector

Interface
REQ-001 Parameters SHALL be: DEPTH, 64, samples per burst; DW, 16, sample width in bits (signed two's complement).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port in_valid, input, 1, sample strobe; connects to the upstream fc2 out_valid.
REQ-006 Port in_sum, input, DW, signed sample; connects to the upstream fc2 sum.
REQ-007 Port clr, input, 1, synchronous abort of a partial burst.
REQ-008 Port rd_addr, input, 6, buffer read index.
REQ-009 Port rd_data, output, DW, registered buffer read data.
REQ-010 Port busy, output, 1, burst capture in progress.
REQ-011 Port done, output, 1, one-cycle pulse: a full burst has been captured.
REQ-012 Port max_idx, output, 6, argmax index of the last complete burst.
REQ-013 Port max_val, output, DW, maximum value of the last complete burst.
REQ-014 Port frame_cnt, output, 8, count of completed bursts.

Function
REQ-015 The FSM SHALL have two states:
- IDLE: sample counter cnt == 0.
- CAPT: 0 < cnt < DEPTH.
- IDLE->CAPT on an accepted sample.
- CAPT->IDLE on acceptance of sample DEPTH-1 or on clr.
REQ-016 A sample SHALL be accepted on every rising edge with in_valid=1 and clr=0, written to buf[cnt], and cnt SHALL then increment.
REQ-017 in_valid gaps inside a burst SHALL hold cnt and the running maximum; capture resumes on the next in_valid.
REQ-018 The sample at cnt==0 SHALL load the running max and index unconditionally.
REQ-019 A later sample SHALL replace the running max only if strictly greater (signed), so ties keep the lowest index.
REQ-020 On acceptance of sample DEPTH-1, the following cycle SHALL show all of:
- done=1 for exactly one cycle;
- max_idx and max_val updated;
- frame_cnt incremented (wraps 255->0);
- cnt=0.
REQ-021 A sample accepted in the cycle where done=1 SHALL be index 0 of the next burst; back-to-back bursts lose no samples.
REQ-022 max_idx and max_val SHALL hold their values until the next completed burst; partial or aborted bursts never alter them.
REQ-023 rd_data SHALL equal buf[rd_addr] one cycle after rd_addr is presented.
REQ-024 When reading and writing the same address in one cycle, rd_data SHALL return the old content.
REQ-025 busy SHALL equal (state==CAPT), combinationally from the state register.
REQ-026 clr SHALL take priority over in_valid: the sample is dropped, cnt=0, the running max is discarded and done stays 0.
REQ-027 No arithmetic SHALL widen or saturate; stored values are exactly DW bits.

Reset
REQ-028 rst SHALL asynchronously force all of: state=IDLE, cnt=0, busy=0, done=0, max_idx=0, max_val=0, frame_cnt=0, rd_data=0, running max/index=0.
REQ-029 Buffer contents SHALL NOT be reset; reads before the first write return undefined data.
REQ-030 rst asserted mid-burst SHALL discard the partial burst; the first sample after deassertion is index 0.

Configuration
REQ-031 With macro FC2_COLLECT_RELU_EN defined, each accepted sample SHALL be clamped (negative -> 0) before storage and before the max comparison.
REQ-032 With FC2_COLLECT_RELU_EN undefined, samples SHALL be stored and compared raw (signed).
REQ-033 All other behaviour SHALL be identical in both builds.

Verification
REQ-034 Contiguous burst in_sum[k]=k-32, k=0..63 -> done one cycle after the last sample, max_idx=63, max_val=31, frame_cnt=1; rd_addr=5 gives rd_data=-27 (RELU_EN: 0).
REQ-035 All 64 samples = 0x7FFF -> max_idx=0 (tie rule).
REQ-036 Burst where every sample = -5 and the sample at k=40 = -1 -> no RELU: max_idx=40, max_val=-1; RELU_EN: max_idx=0, max_val=0.
REQ-037 Burst with in_valid low for 3 cycles after sample 20 -> done once, after sample 63 only; buffer contents correct.
REQ-038 clr (or rst) after 30 samples, then a full burst -> max outputs reflect only the full burst; frame_cnt increments once.
REQ-039 Two bursts back-to-back with no idle cycle -> two done pulses 64 cycles apart, frame_cnt=2, second burst's max reported.

Source files
------------

// File: rtl/fc2_collector_if.sv
// fc2_collector_if -- sample/readback bundle for the fc2 burst collector.
//
// Signals:
//   in_valid  : sample strobe from the upstream fc2 stage
//   in_sum    : signed sample, DW bits
//   clr       : synchronous abort of a partial burst
//   rd_addr   : buffer read index
//   rd_data   : registered buffer read data
//   busy      : burst capture in progress
//   done      : one-cycle pulse when a full burst has been captured
//   max_idx   : argmax index of the last complete burst
//   max_val   : maximum value of the last complete burst
//   frame_cnt : count of completed bursts (wraps)
//
// Modports: master drives samples and read address, slave is the collector.
interface fc2_collector_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic signed [DW-1:0] in_sum;
    logic                 clr;
    logic        [5:0]    rd_addr;
    logic signed [DW-1:0] rd_data;
    logic                 busy;
    logic                 done;
    logic        [5:0]    max_idx;
    logic signed [DW-1:0] max_val;
    logic        [7:0]    frame_cnt;

    modport master (
        output in_valid, in_sum, clr, rd_addr,
        input  rd_data, busy, done, max_idx, max_val, frame_cnt
    );

    modport slave (
        input  in_valid, in_sum, clr, rd_addr,
        output rd_data, busy, done, max_idx, max_val, frame_cnt
    );
endinterface

// File: rtl/fc2_collector.sv
// fc2_collector -- captures DEPTH-sample bursts from the fc2 stage into a
// buffer, tracks the running signed maximum / argmax, and publishes the
// result of each completed burst.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fc2_collector_if.slave (samples in, readback and burst results out)
//
// Parameters: DEPTH (samples per burst), DW (signed sample width).
//
// Build option: define FC2_COLLECT_RELU_EN to clamp negative samples to zero
// before they are stored and compared.
module fc2_collector #(
    parameter int DEPTH = 64,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    fc2_collector_if.slave      bus
);
    typedef enum logic {IDLE, CAPT} state_t;

    localparam logic [5:0] CNT_LAST = 6'(DEPTH - 1);

    state_t               state_q;
    logic        [5:0]    cnt_q;
    logic signed [DW-1:0] run_max_q;
    logic        [5:0]    run_idx_q;
    logic                 done_q;
    logic        [5:0]    max_idx_q;
    logic signed [DW-1:0] max_val_q;
    logic        [7:0]    frame_cnt_q;
    logic signed [DW-1:0] rd_data_q;

    // Sample buffer: data only, never reset.
    logic signed [DW-1:0] mem [0:DEPTH-1];

    function automatic logic signed [DW-1:0] condition_sample(input logic signed [DW-1:0] x);
`ifdef FC2_COLLECT_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    logic signed [DW-1:0] samp;
    logic                 accept;
    logic                 take;

    assign samp   = condition_sample(bus.in_sum);
    assign accept = bus.in_valid && !bus.clr;
    // First sample always seeds the maximum; later ones must be strictly
    // greater so ties keep the lowest index.
    assign take   = (cnt_q == 6'd0) || (samp > run_max_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            done_q      <= 1'b0;
            max_idx_q   <= '0;
            max_val_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.clr) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                run_max_q <= '0;
                run_idx_q <= '0;
            end else if (accept) begin
                if (cnt_q == CNT_LAST) begin
                    // Final sample folds straight into the published result.
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    done_q      <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                    if (take) begin
                        max_val_q <= samp;
                        max_idx_q <= cnt_q;
                    end else begin
                        max_val_q <= run_max_q;
                        max_idx_q <= run_idx_q;
                    end
                end else begin
                    state_q <= CAPT;
                    cnt_q   <= cnt_q + 6'd1;
                    if (take) begin
                        run_max_q <= samp;
                        run_idx_q <= cnt_q;
                    end
                end
            end
        end
    end

    // Buffer write; the read below sees the pre-write content on a collision.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[cnt_q] <= samp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    assign bus.busy      = (state_q == CAPT);
    assign bus.done      = done_q;
    assign bus.max_idx   = max_idx_q;
    assign bus.max_val   = max_val_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_fc2_collector.sv
module tb_fc2_collector;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fc2_collector_if #(.DW(DW)) bus ();

    fc2_collector #(.DEPTH(64), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive one accepted sample; returns 1 ns after the capturing edge.
    task automatic send(input logic signed [DW-1:0] v);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sum   = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic read_at(input logic [5:0] a, output logic signed [DW-1:0] d);
        @(negedge clk);
        bus.rd_addr = a;
        @(posedge clk);
        #1;
        d = bus.rd_data;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_sum   = '0;
        bus.clr      = 1'b0;
        bus.rd_addr  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.max_idx !== 6'd0 || bus.max_val !== 16'sd0 || bus.frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_max: idx=%0d val=%0d frames=%0d required 0 0 0",
                     bus.max_idx, bus.max_val, bus.frame_cnt);
        end
        n_checks++;
        if (bus.rd_data !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %0d required 0", bus.rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        logic signed [DW-1:0] d;
        logic signed [DW-1:0] exp_rd;
        int dones = 0;
        for (int k = 0; k < 64; k++) begin
            send(DW'(k - 32));
            if (bus.done === 1'b1) dones++;
            if (k == 0) begin
                n_checks++;
                if (bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ramp_busy: got %b required 1", bus.busy);
                end
            end
        end
        n_checks++;
        if (dones !== 1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_done: pulses=%0d done=%b busy=%b required 1 1 0", dones, bus.done, bus.busy);
        end
        n_checks++;
        if (bus.max_idx !== 6'd63 || bus.max_val !== 16'sd31 || bus.frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ramp_max: idx=%0d val=%0d frames=%0d required 63 31 1",
                     bus.max_idx, bus.max_val, bus.frame_cnt);
        end
        idle_cycle();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_done_width: done=%b required 0", bus.done);
        end
`ifdef FC2_COLLECT_RELU_EN
        exp_rd = 16'sd0;
`else
        exp_rd = -16'sd27;
`endif
        read_at(6'd5, d);
        n_checks++;
        if (d !== exp_rd) begin
            n_fail++;
            $display("FAIL ramp_read5: got %0d required %0d", d, exp_rd);
        end
    endtask

    task automatic test_ties();
        for (int k = 0; k < 64; k++) send(16'sh7FFF);
        n_checks++;
        if (bus.max_idx !== 6'd0 || bus.max_val !== 16'sh7FFF || bus.frame_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ties: idx=%0d val=%0d frames=%0d required 0 32767 2",
                     bus.max_idx, bus.max_val, bus.frame_cnt);
        end
        idle_cycle();
    endtask

    task automatic test_negative();
        logic [5:0] exp_idx;
        logic signed [DW-1:0] exp_val;
        for (int k = 0; k < 64; k++) send((k == 40) ? -16'sd1 : -16'sd5);
`ifdef FC2_COLLECT_RELU_EN
        exp_idx = 6'd0;
        exp_val = 16'sd0;
`else
        exp_idx = 6'd40;
        exp_val = -16'sd1;
`endif
        n_checks++;
        if (bus.max_idx !== exp_idx || bus.max_val !== exp_val || bus.frame_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL negative: idx=%0d val=%0d frames=%0d required %0d %0d 3",
                     bus.max_idx, bus.max_val, bus.frame_cnt, exp_idx, exp_val);
        end
        idle_cycle();
    endtask

    task automatic test_gap();
        logic signed [DW-1:0] d;
        int dones = 0;
        int gap_bad = 0;
        for (int k = 0; k < 64; k++) begin
            send((k == 50) ? 16'sd1000 : DW'(k));
            if (bus.done === 1'b1 && k != 63) dones += 100;
            if (bus.done === 1'b1 && k == 63) dones++;
            if (k == 20) begin
                for (int g = 0; g < 3; g++) begin
                    idle_cycle();
                    if (bus.busy !== 1'b1 || bus.done !== 1'b0) gap_bad++;
                end
            end
        end
        n_checks++;
        if (gap_bad !== 0) begin
            n_fail++;
            $display("FAIL gap_hold: bad gap cycles=%0d required 0", gap_bad);
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL gap_done: pulse code=%0d required 1", dones);
        end
        n_checks++;
        if (bus.max_idx !== 6'd50 || bus.max_val !== 16'sd1000 || bus.frame_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL gap_max: idx=%0d val=%0d frames=%0d required 50 1000 4",
                     bus.max_idx, bus.max_val, bus.frame_cnt);
        end
        read_at(6'd20, d);
        n_checks++;
        if (d !== 16'sd20) begin
            n_fail++;
            $display("FAIL gap_read20: got %0d required 20", d);
        end
        read_at(6'd21, d);
        n_checks++;
        if (d !== 16'sd21) begin
            n_fail++;
            $display("FAIL gap_read21: got %0d required 21", d);
        end
        read_at(6'd50, d);
        n_checks++;
        if (d !== 16'sd1000) begin
            n_fail++;
            $display("FAIL gap_read50: got %0d required 1000", d);
        end
    endtask

    task automatic test_clr();
        logic signed [DW-1:0] d;
        for (int k = 0; k < 30; k++) send(16'sd2000);
        // clr together with a valid sample: the sample must be dropped.
        @(negedge clk);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sum   = 16'sd5000;
        @(posedge clk);
        #1;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.max_idx !== 6'd50 || bus.max_val !== 16'sd1000) begin
            n_fail++;
            $display("FAIL clr_abort: busy=%b done=%b idx=%0d val=%0d required 0 0 50 1000",
                     bus.busy, bus.done, bus.max_idx, bus.max_val);
        end
        for (int k = 0; k < 64; k++) send(DW'(k));
        n_checks++;
        if (bus.max_idx !== 6'd63 || bus.max_val !== 16'sd63 || bus.frame_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL clr_full: idx=%0d val=%0d frames=%0d required 63 63 5",
                     bus.max_idx, bus.max_val, bus.frame_cnt);
        end
        read_at(6'd10, d);
        n_checks++;
        if (d !== 16'sd10) begin
            n_fail++;
            $display("FAIL clr_read10: got %0d required 10", d);
        end
    endtask

    task automatic test_back_to_back();
        int first_done = -1;
        int second_done = -1;
        int extra = 0;
        for (int j = 0; j < 128; j++) begin
            send((j < 64) ? DW'(j) : DW'(100 - (j - 64)));
            if (bus.done === 1'b1) begin
                if (first_done < 0) first_done = j;
                else if (second_done < 0) second_done = j;
                else extra++;
            end
        end
        n_checks++;
        if (first_done !== 63 || second_done !== 127 || extra !== 0) begin
            n_fail++;
            $display("FAIL b2b_done: pulses at %0d,%0d extra=%0d required 63,127 0",
                     first_done, second_done, extra);
        end
        n_checks++;
        if (bus.max_idx !== 6'd0 || bus.max_val !== 16'sd100 || bus.frame_cnt !== 8'd7) begin
            n_fail++;
            $display("FAIL b2b_max: idx=%0d val=%0d frames=%0d required 0 100 7",
                     bus.max_idx, bus.max_val, bus.frame_cnt);
        end
        // Read and write address 0 in the same cycle: old content returned.
        @(negedge clk);
        bus.rd_addr  = 6'd0;
        bus.in_valid = 1'b1;
        bus.in_sum   = 16'sd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.rd_data !== 16'sd100) begin
            n_fail++;
            $display("FAIL rdw_old: got %0d required 100", bus.rd_data);
        end
        idle_cycle();
        n_checks++;
        if (bus.rd_data !== 16'sd7 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rdw_new: rd_data=%0d busy=%b required 7 1", bus.rd_data, bus.busy);
        end
        @(negedge clk);
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.max_idx !== 6'd0 || bus.max_val !== 16'sd100) begin
            n_fail++;
            $display("FAIL clr_partial: busy=%b idx=%0d val=%0d required 0 0 100",
                     bus.busy, bus.max_idx, bus.max_val);
        end
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 30; k++) send(16'sd3000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.frame_cnt !== 8'd0 || bus.max_val !== 16'sd0) begin
            n_fail++;
            $display("FAIL rst_async: busy=%b frames=%0d val=%0d required 0 0 0",
                     bus.busy, bus.frame_cnt, bus.max_val);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 64; k++) send((k == 0) ? 16'sd500 : DW'(k));
        n_checks++;
        if (bus.max_idx !== 6'd0 || bus.max_val !== 16'sd500 || bus.frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_full: idx=%0d val=%0d frames=%0d required 0 500 1",
                     bus.max_idx, bus.max_val, bus.frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_ties();
        test_negative();
        test_gap();
        test_clr();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
